// File: rtl/ir_fetch_sequencer.sv
// Fetch/decode sequencer for the 19-bit CPU: owns the PC, fetches over a
// req/ack read port, loads the IR, waits for the opcode, launches execute.
//
// state    | meaning
// S_FETCH  | read request outstanding at pc (req held until ack)
// S_LOAD   | LOAD_REG strobe, IR captures instr_out
// S_SETTLE | IR opcode register stage settling
// S_DECODE | opcode inspected, halt or launch execute
// S_EXEC   | waiting for exec_done, then PC update and retire
// S_HALT   | stopped until reset
module ir_fetch_sequencer #(
  parameter int WORD_SIZE = 19,
  parameter int OPCODE_W  = 5,
  parameter int ADDR_W    = 14,
  parameter int SEL_W     = 3,
  parameter logic [SEL_W-1:0]    LOAD_IR_SEL = 3'd0,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE = 5'h1F,
  parameter logic [ADDR_W-1:0]   RESET_PC    = 14'h0000
) (
  input  logic                 CLK,
  input  logic                 RST,
  output logic                 mem_rd_req,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic                 mem_rd_ack,
  input  logic [WORD_SIZE-1:0] mem_rd_data,
  output logic [WORD_SIZE-1:0] instr_out,
  output logic                 LOAD_REG,
  output logic [SEL_W-1:0]     LOAD_SELECT,
  input  logic [OPCODE_W-1:0]  OPCODE,
  output logic                 exec_start,
  input  logic                 exec_done,
  input  logic                 branch_taken,
  input  logic [ADDR_W-1:0]    branch_target,
  output logic [ADDR_W-1:0]    pc,
  output logic                 halted,
  output logic [15:0]          retire_count
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic [2:0] state;

  // pc is itself a register, so the address port stays a registered output
  assign mem_addr = pc;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_FETCH;
      pc           <= RESET_PC;
      instr_out    <= '0;
      mem_rd_req   <= 1'b0;
      LOAD_REG     <= 1'b0;
      LOAD_SELECT  <= LOAD_IR_SEL;
      exec_start   <= 1'b0;
      halted       <= 1'b0;
      retire_count <= 16'd0;
    end else begin
      LOAD_REG    <= 1'b0;
      LOAD_SELECT <= LOAD_IR_SEL;
      exec_start  <= 1'b0;
      case (state)
        S_FETCH: begin
          if (!mem_rd_req) begin
            mem_rd_req <= 1'b1;
          end else if (mem_rd_ack) begin
            instr_out  <= mem_rd_data;
            mem_rd_req <= 1'b0;
            LOAD_REG   <= 1'b1;
            state      <= S_LOAD;
          end
        end
        S_LOAD:   state <= S_SETTLE;
        S_SETTLE: state <= S_DECODE;
        S_DECODE: begin
          if (OPCODE == HALT_OPCODE) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            exec_start <= 1'b1;
            state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (exec_done) begin
            pc <= branch_taken ? branch_target : pc + ADDR_W'(1);
            if (retire_count != 16'hFFFF)
              retire_count <= retire_count + 16'd1;
            // next fetch request goes out together with the new pc
            mem_rd_req <= 1'b1;
            state      <= S_FETCH;
          end
        end
        S_HALT:  halted <= 1'b1;
        default: state  <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_fetch_sequencer.sv
// Randomized bench for ir_fetch_sequencer with an instruction-level model of
// pc / retire count and a small IR model that feeds OPCODE back.
module tb_ir_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        mem_rd_req;
  logic [13:0] mem_addr;
  logic        mem_rd_ack;
  logic [18:0] mem_rd_data;
  logic [18:0] instr_out;
  logic        LOAD_REG;
  logic [2:0]  LOAD_SELECT;
  logic [4:0]  OPCODE = 5'd0;
  logic        exec_start;
  logic        exec_done;
  logic        branch_taken;
  logic [13:0] branch_target;
  logic [13:0] pc;
  logic        halted;
  logic [15:0] retire_count;

  always #5 CLK = ~CLK;

  ir_fetch_sequencer dut (
    .CLK(CLK), .RST(RST),
    .mem_rd_req(mem_rd_req), .mem_addr(mem_addr),
    .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data),
    .instr_out(instr_out), .LOAD_REG(LOAD_REG), .LOAD_SELECT(LOAD_SELECT),
    .OPCODE(OPCODE), .exec_start(exec_start), .exec_done(exec_done),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(pc), .halted(halted), .retire_count(retire_count)
  );

  // IR with its extra opcode register stage
  logic [18:0] ir_q = 19'd0;
  always @(posedge CLK) begin
    if (LOAD_REG && LOAD_SELECT == 3'd0) ir_q <= instr_out;
    OPCODE <= ir_q[18:14];
  end

  int n_checks = 0;
  int n_pass   = 0;
  int m_pc     = 0;
  int m_ret    = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req"}, mem_rd_req, 0);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_instr"}, instr_out, 0);
    chk({tag, "_load"}, LOAD_REG, 0);
    chk({tag, "_sel"}, LOAD_SELECT, 0);
    chk({tag, "_xs"}, exec_start, 0);
    chk({tag, "_halt"}, halted, 0);
    chk({tag, "_ret"}, retire_count, 0);
  endtask

  task automatic model_reset;
    m_pc  = 0;
    m_ret = 0;
  endtask

  // fetch through decode; ends in the first execute cycle (or halt)
  task automatic do_fetch(input logic [18:0] d, input int ack_dly, input bit is_halt);
    int w = 0;
    while (!mem_rd_req && w < 3) begin
      mem_rd_ack = 1'b0;
      tick;
      w++;
    end
    chk("req_up", mem_rd_req, 1);
    chk("fetch_addr", mem_addr, m_pc);
    for (int i = 0; i < ack_dly; i++) begin
      mem_rd_ack  = 1'b0;
      mem_rd_data = 19'($urandom);
      exec_done   = 1'($urandom);
      tick;
      chk("req_hold", mem_rd_req, 1);
      chk("addr_hold", mem_addr, m_pc);
      chk("no_load_wait", LOAD_REG, 0);
    end
    mem_rd_ack  = 1'b1;
    mem_rd_data = d;
    exec_done   = 1'b0;
    tick;
    mem_rd_ack  = 1'($urandom);
    mem_rd_data = 19'($urandom);
    chk("req_drop", mem_rd_req, 0);
    chk("load_strobe", LOAD_REG, 1);
    chk("load_sel", LOAD_SELECT, 0);
    chk("instr_out", instr_out, d);
    chk("xs_early", exec_start, 0);
    tick;
    chk("load_once", LOAD_REG, 0);
    chk("instr_hold", instr_out, d);
    tick;
    chk("xs_decode", exec_start, 0);
    tick;
    mem_rd_ack = 1'b0;
    if (is_halt) begin
      chk("halted", halted, 1);
      chk("xs_halt", exec_start, 0);
    end else begin
      chk("xs_latency", exec_start, 1);
      chk("not_halted", halted, 0);
    end
  endtask

  task automatic do_exec(input int exec_dly, input logic tk, input logic [13:0] tgt);
    for (int i = 0; i < exec_dly; i++) begin
      exec_done     = 1'b0;
      branch_taken  = 1'($urandom);
      branch_target = 14'($urandom);
      tick;
      chk("xs_once", exec_start, 0);
      chk("pc_wait", pc, m_pc);
    end
    exec_done     = 1'b1;
    branch_taken  = tk;
    branch_target = tgt;
    tick;
    exec_done = 1'b0;
    m_pc  = tk ? int'(tgt) : (m_pc + 1) % 16384;
    m_ret = (m_ret < 65535) ? m_ret + 1 : 65535;
    chk("pc_next", pc, m_pc);
    chk("retire", retire_count, m_ret);
    chk("xs_after", exec_start, 0);
    chk("next_req", mem_rd_req, 1);
    chk("next_addr", mem_addr, m_pc);
  endtask

  task automatic run_instr(input logic [18:0] d, input int ack_dly, input int exec_dly,
                           input logic tk, input logic [13:0] tgt);
    do_fetch(d, ack_dly, 1'b0);
    do_exec(exec_dly, tk, tgt);
  endtask

  function automatic logic [18:0] rand_instr();
    logic [4:0] op = 5'($urandom_range(0, 30));
    return {op, 14'($urandom)};
  endfunction

  initial begin
    RST = 1'b1;
    mem_rd_ack = 1'b0; mem_rd_data = 19'd0;
    exec_done = 1'b0; branch_taken = 1'b0; branch_target = 14'd0;
    repeat (3) tick;
    check_reset("rst");

    // release with a spurious ack while req is still low
    RST = 1'b0;
    mem_rd_ack = 1'b1;
    mem_rd_data = 19'h7FFFF;
    tick;
    chk("req_after_rel", mem_rd_req, 1);
    chk("addr_after_rel", mem_addr, 0);
    chk("spurious_ack", instr_out, 0);
    chk("spurious_load", LOAD_REG, 0);
    run_instr(19'h02345, 0, 0, 1'b0, 14'd0);

    run_instr(rand_instr(), 5, 2, 1'b0, 14'd0);
    run_instr(rand_instr(), 1, 0, 1'b1, 14'h3FFF);
    run_instr(rand_instr(), 0, 1, 1'b0, 14'd0);
    chk("wrap_pc", pc, 0);
    run_instr(rand_instr(), 2, 0, 1'b1, 14'h0100);
    chk("branch_addr", mem_addr, 14'h0100);

    for (int k = 0; k < 25; k++)
      run_instr(rand_instr(), $urandom_range(0, 4), $urandom_range(0, 4),
                1'($urandom), 14'($urandom));

    // reset while waiting for a read ack
    mem_rd_ack = 1'b0;
    tick; tick;
    RST = 1'b1;
    mem_rd_ack = 1'b1;
    mem_rd_data = 19'h12345;
    tick;
    check_reset("rst_fetch");
    model_reset();
    RST = 1'b0;
    tick;
    chk("late_ack_instr", instr_out, 0);
    chk("late_ack_load", LOAD_REG, 0);
    chk("restart_addr", mem_addr, 0);
    run_instr(rand_instr(), 1, 1, 1'b0, 14'd0);
    run_instr(rand_instr(), 0, 0, 1'b1, 14'h0ABC);

    // reset while executing
    do_fetch(rand_instr(), 1, 1'b0);
    exec_done = 1'b0;
    tick;
    RST = 1'b1;
    exec_done = 1'b1;
    branch_taken = 1'b1;
    branch_target = 14'h0123;
    tick;
    check_reset("rst_exec");
    model_reset();
    RST = 1'b0;
    tick;
    exec_done = 1'b0;
    chk("late_done_pc", pc, 0);
    chk("late_done_ret", retire_count, 0);
    chk("late_done_req", mem_rd_req, 1);
    run_instr(rand_instr(), 0, 0, 1'b0, 14'd0);
    run_instr(rand_instr(), 3, 2, 1'b1, 14'h2222);

    // halt
    do_fetch({5'h1F, 14'($urandom)}, 1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      mem_rd_ack = 1'($urandom);
      exec_done = 1'($urandom);
      branch_taken = 1'($urandom);
      branch_target = 14'($urandom);
      tick;
      chk("halt_req", mem_rd_req, 0);
      chk("halt_xs", exec_start, 0);
      chk("halt_load", LOAD_REG, 0);
      chk("halt_pc", pc, m_pc);
      chk("halt_ret", retire_count, m_ret);
      chk("halt_flag", halted, 1);
    end

    // saturation: back-to-back single-cycle reads and executes
    RST = 1'b1;
    tick;
    RST = 1'b0;
    model_reset();
    mem_rd_ack = 1'b1;
    mem_rd_data = 19'd0;
    exec_done = 1'b1;
    branch_taken = 1'b0;
    tick;
    repeat (65534 * 5) tick;
    chk("sat_fffe", retire_count, 16'hFFFE);
    repeat (5) tick;
    chk("sat_ffff", retire_count, 16'hFFFF);
    repeat (10) tick;
    chk("sat_hold", retire_count, 16'hFFFF);
    chk("sat_pc", pc, 65537 % 16384);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
